// File: rtl/lbuf_timing_gen_if.sv
// Timing bundle driven by lbuf_timing_gen: raster counters, line-buffer
// read addresses, replication indices, syncs, data enable and window mask.
`timescale 1ns/1ps

interface lbuf_timing_gen_if;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [8:0]  hcnt_lbuf;
    logic [5:0]  vcnt_lbuf;
    logic [2:0]  hctr;
    logic [2:0]  vctr;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic        mask_enable;

    modport master (
        output hcnt, vcnt, hcnt_lbuf, vcnt_lbuf, hctr, vctr,
               HSYNC, VSYNC, DE, mask_enable
    );

    modport slave (
        input  hcnt, vcnt, hcnt_lbuf, vcnt_lbuf, hctr, vctr,
               HSYNC, VSYNC, DE, mask_enable
    );
endinterface

// File: rtl/lbuf_timing_gen.sv
// Output raster timing generator with integer-scaled line-buffer addressing.
// Define FRAMELOCK_EN to restart the frame from the source vsync toggle.
`timescale 1ns/1ps

module lbuf_timing_gen #(
    parameter int H_TOTAL   = 1650,
    parameter int H_SYNCLEN = 40,
    parameter int H_AVSTART = 260,
    parameter int H_ACTIVE  = 1280,
    parameter int V_TOTAL   = 750,
    parameter int V_SYNCLEN = 5,
    parameter int V_AVSTART = 25,
    parameter int V_ACTIVE  = 720,
    parameter int SRC_H     = 384,
    parameter int SRC_V     = 224,
    parameter int H_MULT    = 3,
    parameter int V_MULT    = 3,
    parameter int H_WINOFS  = 64,
    parameter int V_WINOFS  = 24
) (
    input  logic               PCLK_out,
    input  logic               reset_n,
    input  logic               vs_toggle_in,
    lbuf_timing_gen_if.master  tim
);

    // 12-bit bounds so the window end never wraps for the largest rasters.
    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_END  = 12'(H_SYNCLEN);
    localparam logic [11:0] V_SYNC_END  = 12'(V_SYNCLEN);
    localparam logic [11:0] H_DE_START  = 12'(H_AVSTART);
    localparam logic [11:0] H_DE_END    = 12'(H_AVSTART + H_ACTIVE);
    localparam logic [11:0] V_DE_START  = 12'(V_AVSTART);
    localparam logic [11:0] V_DE_END    = 12'(V_AVSTART + V_ACTIVE);
    localparam logic [11:0] H_WIN_START = 12'(H_AVSTART + H_WINOFS);
    localparam logic [11:0] H_WIN_END   = 12'(H_AVSTART + H_WINOFS + SRC_H * H_MULT);
    localparam logic [11:0] V_WIN_START = 12'(V_AVSTART + V_WINOFS);
    localparam logic [11:0] V_WIN_END   = 12'(V_AVSTART + V_WINOFS + SRC_V * V_MULT);
    localparam logic [2:0]  HCTR_LAST   = 3'(H_MULT - 1);
    localparam logic [2:0]  VCTR_LAST   = 3'(V_MULT - 1);
    localparam logic [5:0]  VLBUF_LAST  = 6'd39;

    logic [10:0] hcnt_reg, hcnt_next;
    logic [10:0] vcnt_reg, vcnt_next;
    logic [8:0]  hcnt_lbuf_reg, hcnt_lbuf_next;
    logic [5:0]  vcnt_lbuf_reg, vcnt_lbuf_next;
    logic [2:0]  hctr_reg, hctr_next;
    logic [2:0]  vctr_reg, vctr_next;
    logic        hsync_reg, vsync_reg, de_reg, mask_reg;
    logic        hsync_next, vsync_next, de_next, mask_next;
    logic [11:0] h_pos, v_pos, h_pos_next, v_pos_next;
    logic        h_wrap, hwin_next, vwin_next;
    logic        frame_reload;

`ifdef FRAMELOCK_EN
    // Stages 1-2 synchronise the toggle, stage 3 holds the previous level.
    logic [3:0] vs_chain;
    logic       vs_edge;
    logic       pend_reg;

    assign vs_chain[0] = vs_toggle_in;

    for (genvar gi = 0; gi < 3; gi++) begin : gen_sync
        always_ff @(posedge PCLK_out or negedge reset_n) begin
            if (!reset_n) begin
                vs_chain[gi+1] <= 1'b0;
            end else begin
                vs_chain[gi+1] <= vs_chain[gi];
            end
        end
    end

    assign vs_edge = vs_chain[2] ^ vs_chain[3];

    // Edges merge into one request that is consumed at the next line wrap.
    always_ff @(posedge PCLK_out or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= vs_edge | (pend_reg & ~h_wrap);
        end
    end

    assign frame_reload = pend_reg;
`else
    logic unused_vs_toggle;
    assign unused_vs_toggle = vs_toggle_in;
    assign frame_reload     = 1'b0;
`endif

    // Everything below is derived from the next raster position so that all
    // registered outputs describe the same pixel as hcnt/vcnt.
    always_comb begin
        h_pos     = {1'b0, hcnt_reg};
        v_pos     = {1'b0, vcnt_reg};
        h_wrap    = (h_pos == H_LAST);
        hcnt_next = h_wrap ? 11'd0 : hcnt_reg + 11'd1;
        vcnt_next = vcnt_reg;
        if (h_wrap) begin
            if (frame_reload || (v_pos == V_LAST)) begin
                vcnt_next = 11'd0;
            end else begin
                vcnt_next = vcnt_reg + 11'd1;
            end
        end

        h_pos_next = {1'b0, hcnt_next};
        v_pos_next = {1'b0, vcnt_next};
        hwin_next  = (h_pos_next >= H_WIN_START) && (h_pos_next < H_WIN_END);
        vwin_next  = (v_pos_next >= V_WIN_START) && (v_pos_next < V_WIN_END);
        de_next    = (h_pos_next >= H_DE_START) && (h_pos_next < H_DE_END) &&
                     (v_pos_next >= V_DE_START) && (v_pos_next < V_DE_END);
        mask_next  = de_next && !(hwin_next && vwin_next);
        hsync_next = (h_pos_next >= H_SYNC_END);
        vsync_next = (v_pos_next >= V_SYNC_END);

        hctr_next      = 3'd0;
        hcnt_lbuf_next = 9'd0;
        if (hwin_next && (h_pos_next != H_WIN_START)) begin
            if (hctr_reg == HCTR_LAST) begin
                hctr_next      = 3'd0;
                hcnt_lbuf_next = hcnt_lbuf_reg + 9'd1;
            end else begin
                hctr_next      = hctr_reg + 3'd1;
                hcnt_lbuf_next = hcnt_lbuf_reg;
            end
        end

        vctr_next      = vctr_reg;
        vcnt_lbuf_next = vcnt_lbuf_reg;
        if (h_wrap) begin
            if (!vwin_next || (v_pos_next == V_WIN_START)) begin
                vctr_next      = 3'd0;
                vcnt_lbuf_next = 6'd0;
            end else if (vctr_reg == VCTR_LAST) begin
                vctr_next      = 3'd0;
                vcnt_lbuf_next = (vcnt_lbuf_reg == VLBUF_LAST) ? 6'd0 : vcnt_lbuf_reg + 6'd1;
            end else begin
                vctr_next      = vctr_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge PCLK_out or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_reg      <= 11'd0;
            vcnt_reg      <= 11'd0;
            hcnt_lbuf_reg <= 9'd0;
            vcnt_lbuf_reg <= 6'd0;
            hctr_reg      <= 3'd0;
            vctr_reg      <= 3'd0;
            hsync_reg     <= 1'b1;
            vsync_reg     <= 1'b1;
            de_reg        <= 1'b0;
            mask_reg      <= 1'b0;
        end else begin
            hcnt_reg      <= hcnt_next;
            vcnt_reg      <= vcnt_next;
            hcnt_lbuf_reg <= hcnt_lbuf_next;
            vcnt_lbuf_reg <= vcnt_lbuf_next;
            hctr_reg      <= hctr_next;
            vctr_reg      <= vctr_next;
            hsync_reg     <= hsync_next;
            vsync_reg     <= vsync_next;
            de_reg        <= de_next;
            mask_reg      <= mask_next;
        end
    end

    assign tim.hcnt        = hcnt_reg;
    assign tim.vcnt        = vcnt_reg;
    assign tim.hcnt_lbuf   = hcnt_lbuf_reg;
    assign tim.vcnt_lbuf   = vcnt_lbuf_reg;
    assign tim.hctr        = hctr_reg;
    assign tim.vctr        = vctr_reg;
    assign tim.HSYNC       = hsync_reg;
    assign tim.VSYNC       = vsync_reg;
    assign tim.DE          = de_reg;
    assign tim.mask_enable = mask_reg;

endmodule

// File: tb/tb_lbuf_timing_gen.sv
// Bench for lbuf_timing_gen on a reduced raster: position-based model checked
// every cycle, frame totals, pinned literal points, vsync toggles, async reset.
`timescale 1ns/1ps

module tb_lbuf_timing_gen;

    localparam int H_TOTAL   = 80;
    localparam int H_SYNCLEN = 6;
    localparam int H_AVSTART = 14;
    localparam int H_ACTIVE  = 60;
    localparam int V_TOTAL   = 110;
    localparam int V_SYNCLEN = 3;
    localparam int V_AVSTART = 8;
    localparam int V_ACTIVE  = 96;
    localparam int SRC_H     = 16;
    localparam int SRC_V     = 44;
    localparam int H_MULT    = 3;
    localparam int V_MULT    = 2;
    localparam int H_WINOFS  = 4;
    localparam int V_WINOFS  = 3;
`ifdef FRAMELOCK_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef logic [46:0] vec_t;
    localparam vec_t RESET_VEC = {11'd0, 11'd0, 9'd0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset_n;
    logic vs_toggle_in;

    lbuf_timing_gen_if tim ();

    lbuf_timing_gen #(
        .H_TOTAL(H_TOTAL), .H_SYNCLEN(H_SYNCLEN), .H_AVSTART(H_AVSTART), .H_ACTIVE(H_ACTIVE),
        .V_TOTAL(V_TOTAL), .V_SYNCLEN(V_SYNCLEN), .V_AVSTART(V_AVSTART), .V_ACTIVE(V_ACTIVE),
        .SRC_H(SRC_H), .SRC_V(SRC_V), .H_MULT(H_MULT), .V_MULT(V_MULT),
        .H_WINOFS(H_WINOFS), .V_WINOFS(V_WINOFS)
    ) dut (
        .PCLK_out     (clk),
        .reset_n      (reset_n),
        .vs_toggle_in (vs_toggle_in),
        .tim          (tim.master)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int pos_h = 0, pos_v = 0;
    int frames_done = 0;
    bit m_pend = 1'b0;
    bit frame_on = 1'b0;
    int cnt_clk, cnt_hs, cnt_vs, cnt_de;

    function automatic vec_t pack(logic [10:0] h, logic [10:0] v, logic [8:0] hl, logic [5:0] vl,
                                  logic [2:0] hc, logic [2:0] vc, logic hs, logic vs,
                                  logic de, logic mk);
        return {h, v, hl, vl, hc, vc, hs, vs, de, mk};
    endfunction

    function automatic vec_t dut_vec();
        return pack(tim.hcnt, tim.vcnt, tim.hcnt_lbuf, tim.vcnt_lbuf, tim.hctr, tim.vctr,
                    tim.HSYNC, tim.VSYNC, tim.DE, tim.mask_enable);
    endfunction

    // Expected outputs straight from the raster rules for position (h, v).
    function automatic vec_t model_vec(int h, int v);
        int hws = H_AVSTART + H_WINOFS;
        int vws = V_AVSTART + V_WINOFS;
        bit hw  = (h >= hws) && (h < hws + SRC_H * H_MULT);
        bit vw  = (v >= vws) && (v < vws + SRC_V * V_MULT);
        bit de  = (h >= H_AVSTART) && (h < H_AVSTART + H_ACTIVE) &&
                  (v >= V_AVSTART) && (v < V_AVSTART + V_ACTIVE);
        return pack(11'(h), 11'(v),
                    hw ? 9'((h - hws) / H_MULT) : 9'd0,
                    vw ? 6'(((v - vws) / V_MULT) % 40) : 6'd0,
                    hw ? 3'((h - hws) % H_MULT) : 3'd0,
                    vw ? 3'((v - vws) % V_MULT) : 3'd0,
                    h >= H_SYNCLEN, v >= V_SYNCLEN, de, de && !(hw && vw));
    endfunction

    task automatic chk(string name, int act, int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at (h=%0d,v=%0d): got %0d expected %0d", name, pos_h, pos_v, act, exp);
        end
    endtask

    task automatic chk_vec(string name, vec_t act, vec_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at (h=%0d,v=%0d): got %h expected %h", name, pos_h, pos_v, act, exp);
        end
    endtask

    // Compare process: model follows the raster, checked 1ns after each edge.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            chk_vec("reset_state", dut_vec(), RESET_VEC);
            pos_h    = 0;
            pos_v    = 0;
            frame_on = 1'b0;
        end else begin
            if (pos_h == H_TOTAL - 1) begin
                pos_h = 0;
                if (m_pend) begin
                    pos_v    = 0;
                    m_pend   = 1'b0;
                    frame_on = 1'b0;
                end else begin
                    pos_v = (pos_v == V_TOTAL - 1) ? 0 : pos_v + 1;
                end
            end else begin
                pos_h = pos_h + 1;
            end
            chk_vec("model", dut_vec(), model_vec(pos_h, pos_v));

            if (pos_v == 11 && pos_h == 18) begin chk("hctr_first", tim.hctr, 0); chk("hlbuf_first", tim.hcnt_lbuf, 0); end
            if (pos_v == 11 && pos_h == 20) begin chk("hctr_third", tim.hctr, 2); chk("hlbuf_third", tim.hcnt_lbuf, 0); end
            if (pos_v == 11 && pos_h == 21) begin chk("hctr_wrap", tim.hctr, 0); chk("hlbuf_step", tim.hcnt_lbuf, 1); end
            if (pos_v == 11 && pos_h == 65) begin chk("hctr_last", tim.hctr, 2); chk("hlbuf_last", tim.hcnt_lbuf, 15); end
            if (pos_v == 11 && pos_h == 66) begin chk("hctr_out", tim.hctr, 0); chk("hlbuf_out", tim.hcnt_lbuf, 0); end
            if (pos_v == 90 && pos_h == 0)  begin chk("vctr_pre", tim.vctr, 1); chk("vlbuf_39", tim.vcnt_lbuf, 39); end
            if (pos_v == 91 && pos_h == 0)  begin chk("vctr_wrap", tim.vctr, 0); chk("vlbuf_wrap", tim.vcnt_lbuf, 0); end
            if (pos_v == 99 && pos_h == 0)  chk("vlbuf_out", tim.vcnt_lbuf, 0);
            if (pos_v == 50 && pos_h == 16) begin chk("de_border", tim.DE, 1); chk("mask_border", tim.mask_enable, 1); end
            if (pos_v == 50 && pos_h == 30) begin chk("de_window", tim.DE, 1); chk("mask_window", tim.mask_enable, 0); end
            if (pos_v == 2 && pos_h == 0)   chk("vsync_last_low", tim.VSYNC, 0);
            if (pos_v == 3 && pos_h == 0)   chk("vsync_high", tim.VSYNC, 1);
            if (pos_v == 20 && pos_h == 5)  chk("hsync_last_low", tim.HSYNC, 0);
            if (pos_v == 20 && pos_h == 6)  chk("hsync_high", tim.HSYNC, 1);

            if (pos_h == 0 && pos_v == 0) begin
                if (frame_on) begin
                    chk("frame_clocks", cnt_clk, 8800);
                    chk("frame_hsync_low", cnt_hs, 660);
                    chk("frame_vsync_low", cnt_vs, 240);
                    chk("frame_de", cnt_de, 5760);
                    frames_done++;
                end
                frame_on = 1'b1;
                cnt_clk = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
            end
            if (frame_on) begin
                cnt_clk++;
                cnt_hs += int'(!tim.HSYNC);
                cnt_vs += int'(!tim.VSYNC);
                cnt_de += int'(tim.DE);
            end
        end
    end

    task automatic wait_pos(string name, int h, int v, int max_cyc);
        int n = 0;
        @(negedge clk);
        while (!(pos_h == h && pos_v == v) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: got (h=%0d,v=%0d) expected (h=%0d,v=%0d)", name, pos_h, pos_v, h, v);
        end
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        vs_toggle_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release_h0", tim.hcnt, 0);
        @(posedge clk);
        #2;
        chk("release_h1", tim.hcnt, 1);
        chk("release_v0", tim.vcnt, 0);

        n = 0;
        while (frames_done < 2 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("frames_seen", frames_done, 2);

        wait_pos("toggle1", 20, 30, 10000);
        vs_toggle_in = ~vs_toggle_in;
        m_pend = FL;
        wait_pos("toggle2", 40, 30, 100);
        vs_toggle_in = ~vs_toggle_in;
        m_pend = FL;
        wait_pos("line_after_toggle", 0, FL ? 0 : 31, 100);
        chk("framelock_vcnt", tim.vcnt, FL ? 0 : 31);
        repeat (H_TOTAL) @(negedge clk);
        chk("framelock_single", tim.vcnt, FL ? 1 : 32);

        wait_pos("reset_point", 40, 50, 10000);
        reset_n = 1'b0;
        #1;
        chk_vec("async_reset", dut_vec(), RESET_VEC);
        repeat (3) @(negedge clk);
        chk_vec("reset_hold", dut_vec(), RESET_VEC);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk("restart_h", tim.hcnt, 1);
        chk("restart_v", tim.vcnt, 0);
        repeat (200) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lbuf_timing_gen.md
LBUF_TIMING_GEN -- requirements
Module: lbuf_timing_gen

Interface
REQ-001 Parameter H_TOTAL, 1650, output pixels per line.
REQ-002 Parameter H_SYNCLEN, 40, hsync width in pixels.
REQ-003 Parameter H_AVSTART, 260, first active pixel (sync + back porch).
REQ-004 Parameter H_ACTIVE, 1280, active pixels per line.
REQ-005 Parameter V_TOTAL, 750, lines per frame.
REQ-006 Parameter V_SYNCLEN, 5, vsync width in lines.
REQ-007 Parameter V_AVSTART, 25, first active line.
REQ-008 Parameter V_ACTIVE, 720, active lines per frame.
REQ-009 Parameter SRC_H, 384, source pixels per line.
REQ-010 Parameter SRC_V, 224, source lines per frame.
REQ-011 Parameter H_MULT, 3, horizontal scale factor (1..5).
REQ-012 Parameter V_MULT, 3, vertical scale factor (1..5).
REQ-013 Parameter H_WINOFS, 64, picture window offset from H_AVSTART.
REQ-014 Parameter V_WINOFS, 24, picture window offset from V_AVSTART.
REQ-015 PCLK_out  in  1  output pixel clock; all logic on its rising edge.
REQ-016 reset_n  in  1  reset, asynchronous, active-low.
REQ-017 vs_toggle_in  in  1  toggles once per source frame (PCLK_in domain, asynchronous here).
REQ-018 hcnt  out  11  horizontal pixel counter.
REQ-019 vcnt  out  11  line counter.
REQ-020 hcnt_lbuf  out  9  line buffer column read address.
REQ-021 vcnt_lbuf  out  6  line buffer row read address.
REQ-022 hctr  out  3  sub-pixel index within horizontal replication.
REQ-023 vctr  out  3  sub-line index within vertical replication.
REQ-024 HSYNC, VSYNC  out  1 each  syncs, active-low.
REQ-025 DE  out  1  data enable.
REQ-026 mask_enable  out  1  high for active pixels outside the picture window.

Function
REQ-027 hcnt SHALL count 0..H_TOTAL-1 and wrap; vcnt SHALL increment on each hcnt wrap and wrap from V_TOTAL-1 to 0.
REQ-028 HSYNC SHALL be low iff hcnt<H_SYNCLEN; VSYNC SHALL be low iff vcnt<V_SYNCLEN.
REQ-029 DE SHALL be high iff H_AVSTART<=hcnt<H_AVSTART+H_ACTIVE and V_AVSTART<=vcnt<V_AVSTART+V_ACTIVE.
REQ-030 The window is defined as hwin: hcnt in [H_AVSTART+H_WINOFS, +SRC_H*H_MULT), and vwin: vcnt in [V_AVSTART+V_WINOFS, +SRC_V*V_MULT); mask_enable SHALL be high iff DE and not (hwin and vwin).
REQ-031 hctr SHALL be 0 at the first hwin pixel and advance by 1 per pixel, wrapping H_MULT-1 to 0; hcnt_lbuf SHALL be 0 at the first hwin pixel and increment on each hctr wrap; both SHALL be 0 outside hwin.
REQ-032 vctr and vcnt_lbuf SHALL be 0 on the first vwin line and update at line start (hcnt wrap): vctr wraps V_MULT-1 to 0; vcnt_lbuf increments on each vctr wrap, wrapping 39 to 0 (40 line buffers); both SHALL hold 0 outside vwin.
REQ-033 All outputs SHALL be registered and mutually consistent: every output in a given cycle describes the same (hcnt, vcnt) position; latency from counter state to outputs is zero relative to hcnt/vcnt.
REQ-034 Counter arithmetic SHALL use at least 12-bit intermediates so that window bounds never overflow.

Reset
REQ-035 While reset_n is low: hcnt, vcnt, hcnt_lbuf, vcnt_lbuf, hctr, vctr=0; HSYNC, VSYNC=1; DE, mask_enable=0; synchroniser and pending flags=0.
REQ-036 On release, hcnt SHALL be 0 in the first clock edge after deassertion and 1 in the next; assertion mid-frame SHALL abort immediately with no partial pulse.

Configuration
REQ-037 With FRAMELOCK_EN defined: vs_toggle_in SHALL pass a 2-flop synchroniser plus edge detect; a detected edge sets a pending flag, and at the next hcnt wrap vcnt SHALL load 0 (overriding the normal increment or wrap) and clear the flag; edges arriving while the flag is set SHALL merge into it.
REQ-038 Without FRAMELOCK_EN: vs_toggle_in SHALL be ignored and timing runs free; the port remains.

Verification
REQ-039 Reset, run 2 frames at defaults -> 1650*750 clocks per frame; HSYNC low for 40 clocks per line; VSYNC low for lines 0-4; DE high for 1280x720 per frame.
REQ-040 Line vcnt=49 (first vwin line) -> hctr 0,1,2,0 and hcnt_lbuf 0,0,0,1 from hcnt=324; hcnt_lbuf=383, hctr=2 at hcnt=1475; both 0 at hcnt=1476.
REQ-041 vcnt 49..720 -> vcnt_lbuf advances every 3 lines, wraps 39->0 at vcnt=169, and is 0 from vcnt=721.
REQ-042 hcnt=300, vcnt=100 -> DE=1, mask_enable=1; hcnt=400, vcnt=100 -> mask_enable=0.
REQ-043 FRAMELOCK_EN: toggle vs_toggle_in while vcnt=300 -> vcnt=0 at the line start after the 2-3 cycle synchroniser delay; two toggles within one line -> a single reload.
REQ-044 Assert reset_n at hcnt=800, vcnt=400 for 3 cycles -> all outputs at reset values immediately; after release counting restarts from 0,0.
